// File: rtl/bicubic_tap_sequencer.sv
// bicubic_tap_sequencer
//   Time-multiplexed MAC controller for one bicubic filter pass. A job of
//   TAPS sign-magnitude pixel/weight pairs is latched on a valid/ready
//   handshake. One shared bicubic_mult is stepped over the taps, one tap per
//   cycle. The block returns the raw signed sum and an 8-bit result clamped
//   to 0..255.
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   in_valid/in_ready   job handshake
//   in_pixel[8*TAPS]    pixel magnitudes, tap i at [8i+7:8i]
//   in_pixel_sign[TAPS] pixel signs (1 = negative)
//   in_weight[3*TAPS]   weight codes, tap i at [3i+2:3i]
//   in_weight_sign      weight signs (1 = negative)
//   out_valid/out_ready result handshake
//   out_sum[ACC_W]      raw signed sum of tap products
//   out_pixel[8]        out_sum clamped to [0,255]
//   busy                high in MAC or DONE

// bicubic_mult
//   Combinational sign-magnitude multiply of an 8-bit pixel by a coded
//   weight (0,3,8,9,29,72,111,128)/128. The product is floored and carries a
//   sign; a zero product is always positive.
module bicubic_mult (
  input  logic [7:0] pixel_i,
  input  logic       pixel_sign_i,
  input  logic [2:0] wcode_i,
  input  logic       wsign_i,
  output logic [7:0] prod_o,
  output logic       prod_sign_o
);

  logic [7:0] weight;

  always_comb begin
    weight = '0;
    unique case (wcode_i)
      3'd0: weight = 8'd0;
      3'd1: weight = 8'd3;
      3'd2: weight = 8'd8;
      3'd3: weight = 8'd9;
      3'd4: weight = 8'd29;
      3'd5: weight = 8'd72;
      3'd6: weight = 8'd111;
      3'd7: weight = 8'd128;
      default: weight = 8'd0;
    endcase
  end

  // 128*255 fits in 15 bits, so bits [14:7] hold the whole floored product.
  assign prod_o      = 8'((16'(weight) * 16'(pixel_i)) >> 7);
  assign prod_sign_o = (pixel_sign_i ^ wsign_i) & (|prod_o);

endmodule

module bicubic_tap_sequencer #(
  parameter  int unsigned TAPS  = 4,
  localparam int unsigned ACC_W = 8 + $clog2(TAPS) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [8*TAPS-1:0]   in_pixel,
  input  logic [TAPS-1:0]     in_pixel_sign,
  input  logic [3*TAPS-1:0]   in_weight,
  input  logic [TAPS-1:0]     in_weight_sign,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ACC_W-1:0]    out_sum,
  output logic [7:0]          out_pixel,
  output logic                busy
);

  localparam int unsigned IDX_W = $clog2(TAPS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [IDX_W-1:0]    tap_idx_q, tap_idx_d;
  logic [8*TAPS-1:0]   pix_q, pix_d;
  logic [TAPS-1:0]     pixs_q, pixs_d;
  logic [3*TAPS-1:0]   w_q, w_d;
  logic [TAPS-1:0]     ws_q, ws_d;
  logic [ACC_W-1:0]    out_sum_q, out_sum_d;
  logic [7:0]          out_pixel_q, out_pixel_d;

  logic [7:0]          cur_pix;
  logic                cur_ps;
  logic [2:0]          cur_w;
  logic                cur_ws;
  logic [7:0]          prod;
  logic                prod_sign;
  logic [ACC_W-1:0]    prod_ext;
  logic [ACC_W-1:0]    acc_mac;

  function automatic logic [7:0] clamp_pix(input logic [ACC_W-1:0] v);
    if (v[ACC_W-1])
      return '0;
    else if (|v[ACC_W-2:8])
      return '1;
    else
      return v[7:0];
  endfunction

  // Tap select from the job registers only.
  always_comb begin
    cur_pix = '0;
    cur_ps  = 1'b0;
    cur_w   = '0;
    cur_ws  = 1'b0;
    for (int unsigned i = 0; i < TAPS; i++) begin
      if (tap_idx_q == IDX_W'(i)) begin
        cur_pix = pix_q[8*i +: 8];
        cur_ps  = pixs_q[i];
        cur_w   = w_q[3*i +: 3];
        cur_ws  = ws_q[i];
      end
    end
  end

  bicubic_mult u_mult (
    .pixel_i      (cur_pix),
    .pixel_sign_i (cur_ps),
    .wcode_i      (cur_w),
    .wsign_i      (cur_ws),
    .prod_o       (prod),
    .prod_sign_o  (prod_sign)
  );

  assign prod_ext = {{(ACC_W-8){1'b0}}, prod};
  assign acc_mac  = prod_sign ? (acc_q - prod_ext) : (acc_q + prod_ext);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    tap_idx_d   = tap_idx_q;
    pix_d       = pix_q;
    pixs_d      = pixs_q;
    w_d         = w_q;
    ws_d        = ws_q;
    out_sum_d   = out_sum_q;
    out_pixel_d = out_pixel_q;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
      end
      S_MAC: begin
        busy      = 1'b1;
        acc_d     = acc_mac;
        tap_idx_d = tap_idx_q + IDX_W'(1);
        if (tap_idx_q == IDX_W'(TAPS-1)) begin
          state_d     = S_DONE;
          tap_idx_d   = '0;
          out_sum_d   = acc_mac;
          out_pixel_d = clamp_pix(acc_mac);
        end
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready && !in_valid)
          state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Accept shared by IDLE and the DONE handshake edge.
    if (in_valid && in_ready) begin
      state_d   = S_MAC;
      acc_d     = '0;
      tap_idx_d = '0;
      pix_d     = in_pixel;
      pixs_d    = in_pixel_sign;
      w_d       = in_weight;
      ws_d      = in_weight_sign;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      tap_idx_q   <= '0;
      pix_q       <= '0;
      pixs_q      <= '0;
      w_q         <= '0;
      ws_q        <= '0;
      out_sum_q   <= '0;
      out_pixel_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      tap_idx_q   <= tap_idx_d;
      pix_q       <= pix_d;
      pixs_q      <= pixs_d;
      w_q         <= w_d;
      ws_q        <= ws_d;
      out_sum_q   <= out_sum_d;
      out_pixel_q <= out_pixel_d;
    end
  end

  assign out_sum   = out_sum_q;
  assign out_pixel = out_pixel_q;

endmodule

// File: tb/tb_bicubic_tap_sequencer.sv
// Directed self-checking bench for bicubic_tap_sequencer (TAPS=4, ACC_W=11).
module tb_bicubic_tap_sequencer;

  localparam int unsigned TAPS  = 4;
  localparam int unsigned ACC_W = 11;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [8*TAPS-1:0] in_pixel;
  logic [TAPS-1:0]   in_pixel_sign;
  logic [3*TAPS-1:0] in_weight;
  logic [TAPS-1:0]   in_weight_sign;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic [7:0]        out_pixel;
  logic              busy;

  int errors;
  int checks;
  int cycles;

  bicubic_tap_sequencer #(.TAPS(TAPS)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_pixel       (in_pixel),
    .in_pixel_sign  (in_pixel_sign),
    .in_weight      (in_weight),
    .in_weight_sign (in_weight_sign),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_sum        (out_sum),
    .out_pixel      (out_pixel),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present a job at a falling edge and let the next rising edge accept it.
  task automatic drive_job(input logic [8*TAPS-1:0] p, input logic [TAPS-1:0] ps,
                           input logic [3*TAPS-1:0] w, input logic [TAPS-1:0] ws);
    @(negedge clk);
    in_valid       = 1'b1;
    in_pixel       = p;
    in_pixel_sign  = ps;
    in_weight      = w;
    in_weight_sign = ws;
  endtask

  // Drop in_valid and scramble the inputs right after acceptance, then count
  // rising edges until out_valid is seen (bounded).
  task automatic wait_result(output int n);
    @(negedge clk);
    in_valid       = 1'b0;
    in_pixel       = '1;
    in_pixel_sign  = '1;
    in_weight      = '1;
    in_weight_sign = '0;
    n = 0;
    while (n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (out_valid) break;
    end
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_pixel = '0;
    in_pixel_sign = '0;
    in_weight = '0;
    in_weight_sign = '0;
    out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", {31'b0, in_ready}, 1);
    check("rst_out_valid", {31'b0, out_valid}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_out_sum", $signed(out_sum), 0);
    check("rst_out_pixel", {24'b0, out_pixel}, 0);
    rst_n = 1'b1;

    // Interpolation: 100 x4, weights -9,+72,+72,-9 -> -7+56+56-7 = 98
    drive_job({4{8'd100}}, 4'b0000, {3'd3, 3'd5, 3'd5, 3'd3}, 4'b1001);
    check("interp_in_ready_pre", {31'b0, in_ready}, 1);
    @(posedge clk);
    #1;
    check("interp_in_ready_mac", {31'b0, in_ready}, 0);
    check("interp_busy_mac", {31'b0, busy}, 1);
    wait_result(cycles);
    check("interp_latency", cycles, 4);
    check("interp_sum", $signed(out_sum), 98);
    check("interp_pixel", {24'b0, out_pixel}, 98);
    consume();
    check("interp_idle_valid", {31'b0, out_valid}, 0);
    check("interp_idle_ready", {31'b0, in_ready}, 1);
    check("interp_idle_busy", {31'b0, busy}, 0);

    // Upper clamp: 255 x4 at +128 -> 1020, pixel 255
    drive_job({4{8'd255}}, 4'b0000, {4{3'd7}}, 4'b0000);
    @(posedge clk);
    wait_result(cycles);
    check("upper_latency", cycles, 4);
    check("upper_sum", $signed(out_sum), 1020);
    check("upper_pixel", {24'b0, out_pixel}, 255);
    consume();

    // Lower clamp: tap0 200 at -128, others weight 0 -> -200, pixel 0
    drive_job({8'd77, 8'd77, 8'd77, 8'd200}, 4'b0000, {3'd0, 3'd0, 3'd0, 3'd7}, 4'b1111);
    @(posedge clk);
    wait_result(cycles);
    check("lower_sum", $signed(out_sum), -200);
    check("lower_pixel", {24'b0, out_pixel}, 0);
    consume();

    // Zero-product sign: tap0 -10 * 3/128 -> 0; taps1..3 50*8/128 -> 3 each
    drive_job({8'd50, 8'd50, 8'd50, 8'd10}, 4'b0001, {3'd2, 3'd2, 3'd2, 3'd1}, 4'b0000);
    @(posedge clk);
    wait_result(cycles);
    check("zero_sum", $signed(out_sum), 9);
    check("zero_pixel", {24'b0, out_pixel}, 9);
    consume();

    // Backpressure then back-to-back
    drive_job({4{8'd100}}, 4'b0000, {3'd3, 3'd5, 3'd5, 3'd3}, 4'b1001);
    @(posedge clk);
    wait_result(cycles);
    check("bp_first_sum", $signed(out_sum), 98);
    // Second job: 20,40,60,-80 at +128 -> 40
    in_valid       = 1'b1;
    in_pixel       = {8'd80, 8'd60, 8'd40, 8'd20};
    in_pixel_sign  = 4'b1000;
    in_weight      = {4{3'd7}};
    in_weight_sign = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_hold_valid", {31'b0, out_valid}, 1);
      check("bp_hold_sum", $signed(out_sum), 98);
      check("bp_hold_pixel", {24'b0, out_pixel}, 98);
      check("bp_hold_in_ready", {31'b0, in_ready}, 0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", {31'b0, in_ready}, 1);
    @(posedge clk);
    #1;
    check("b2b_accept_busy", {31'b0, busy}, 1);
    check("b2b_accept_valid", {31'b0, out_valid}, 0);
    out_ready = 1'b0;
    wait_result(cycles);
    check("b2b_latency", cycles, 4);
    check("b2b_sum", $signed(out_sum), 40);
    check("b2b_pixel", {24'b0, out_pixel}, 40);
    consume();

    // Reset mid-MAC at tap_idx=2
    drive_job({4{8'd255}}, 4'b0000, {4{3'd7}}, 4'b0000);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'b0, out_valid}, 0);
    check("midrst_out_sum", $signed(out_sum), 0);
    check("midrst_out_pixel", {24'b0, out_pixel}, 0);
    check("midrst_in_ready", {31'b0, in_ready}, 1);
    check("midrst_busy", {31'b0, busy}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fresh job after reset: 1,2,3,4 at +128 -> 10
    drive_job({8'd4, 8'd3, 8'd2, 8'd1}, 4'b0000, {4{3'd7}}, 4'b0000);
    @(posedge clk);
    wait_result(cycles);
    check("fresh_latency", cycles, 4);
    check("fresh_sum", $signed(out_sum), 10);
    check("fresh_pixel", {24'b0, out_pixel}, 10);
    consume();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bicubic_tap_sequencer.md
# bicubic_tap_sequencer

Time-multiplexed multiply-accumulate controller for one bicubic filter pass. It accepts one job of TAPS sign-magnitude pixel/weight pairs over a valid/ready handshake and sequences a single internal `bicubic_mult` instance over the taps, one tap per cycle. It accumulates the signed products and returns both the raw signed sum and an 8-bit result clamped to 0..255. It sits between the window/coefficient fetch logic and the output pixel packer of the bicubic upscaler.

## Interface
- TAPS, 4, taps per job; legal range 2..8.
- ACC_W, 8+$clog2(TAPS)+1, accumulator width in two's complement; 11 for TAPS=4. Derived; not overridden.
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  job valid.
- in_ready  out  1  job accepted when in_valid&in_ready.
- in_pixel  in  8*TAPS  pixel magnitudes; tap i is at [8i+7:8i].
- in_pixel_sign  in  TAPS  pixel signs; 1 = negative.
- in_weight  in  3*TAPS  weight codes; tap i is at [3i+2:3i].
  - Codes 0..7 map to weights 0, 3, 8, 9, 29, 72, 111, 128 (each divided by 128).
- in_weight_sign  in  TAPS  weight signs; 1 = negative.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid&out_ready.
- out_sum  out  ACC_W  raw signed sum of the tap products.
- out_pixel  out  8  out_sum clamped to [0,255].
- busy  out  1  high while the FSM is in MAC or DONE.

## Operation
- FSM states are IDLE, MAC and DONE.
- IDLE:
  - in_ready=1.
  - On accept, latch all job inputs into job registers, clear acc to 0, set tap_idx=0, and go to MAC.
- MAC:
  - The multiplier is driven from job registers tap[tap_idx].
  - Each product is floor(w*p/128), which is 8-bit magnitude, plus a sign.
  - A zero product always has sign 0.
  - Each cycle performs acc <= acc ± {0,product}, sign-extended to ACC_W.
  - Each cycle increments tap_idx.
  - On tap_idx==TAPS-1 the FSM goes to DONE; out_sum/out_pixel register the final value on that same edge.
- DONE:
  - out_valid=1, and out_sum/out_pixel are held stable.
  - On out_valid&out_ready:
    - If in_valid is also high, the new job is accepted on the same edge and the FSM goes to MAC. in_ready = out_ready in DONE.
    - Otherwise the FSM goes to IDLE.
- Clamp rule:
  - out_sum<0 gives out_pixel=0.
  - out_sum>255 gives out_pixel=255.
  - Otherwise out_pixel=out_sum[7:0].
- Width rule: ACC_W cannot overflow. The magnitude is at most 255*TAPS.
- Input changes after acceptance have no effect; the job registers are the only source.
- in_ready=0 in MAC.

## Timing
- Reset values:
  - FSM state IDLE, in_ready=1, out_valid=0, busy=0.
  - out_sum=0, out_pixel=0, acc=0, tap_idx=0, job registers 0.
- Reset mid-operation: on rst_n low the block returns immediately to the reset values, and the in-flight job is discarded.
- Latency: with the job accepted at edge k, MAC occupies edges k+1..k+TAPS.
  - out_valid is high after edge k+TAPS, i.e. TAPS cycles after acceptance.
- Throughput with out_ready held at 1 and back-to-back jobs: one result per TAPS+1 cycles.
  - Accept, then TAPS MAC edges; the DONE edge doubles as the next accept.
- Backpressure: out_valid, out_sum and out_pixel are held indefinitely while out_ready=0; no new job is accepted.
- out_ready while out_valid=0 is ignored.

## Test plan
- Interpolation job:
  - Stimulus: pixels 100,100,100,100, all positive; weights -9, +72, +72, -9 (codes 3,5,5,3; signs 1,0,0,1).
  - Required: products 7, 56, 56, 7; out_sum=98; out_pixel=98; out_valid exactly 4 cycles after accept.
- Upper clamp:
  - Stimulus: pixels 255 ×4, weight +128 ×4 (code 7).
  - Required: out_sum=1020; out_pixel=255.
- Lower clamp and sign handling:
  - Stimulus: tap0 pixel 200 (positive), weight -128; taps 1..3 weight code 0.
  - Required: out_sum=-200; out_pixel=0.
- Zero-product sign:
  - Stimulus: tap0 pixel 10 (negative), weight +3 (product 30/128, which floors to 0); taps 1..3 pixel 50 (positive), weight +8.
  - Required: out_sum=9 (0+3+3+3); no negative contribution from tap0.
- Backpressure then back-to-back:
  - Stimulus: hold out_ready=0 for 3 cycles with a second job pending.
  - Required: outputs stable and in_ready=0 during the hold.
  - Stimulus: raise out_ready.
  - Required: the second job is accepted on the same edge as the handshake, and its result appears 4 cycles later.
- Reset mid-MAC:
  - Stimulus: assert rst_n=0 at tap_idx=2.
  - Required: out_valid=0, out_sum=0, in_ready=1 asynchronously.
  - Stimulus: after release, run a fresh job.
  - Required: correct result with no residue from the aborted job.
